fixed_point_alu: RTL and testbench
==================================

# fixed_point_alu

Parametrised, handshaked successor to the core's fixed-point unit: a signed two's-complement Q(WIDTH−FBITS).FBITS arithmetic block serving the FPU-class instructions of the execute stage. Adds start/busy/done handshaking, configurable width and fraction bits, a selectable saturate/wrap policy, rounded multiplication, NEG/ABS, and overflow/invalid flags. Multiply and square root are iterative, one bit per cycle; other operations complete in one cycle.

## Interface
- WIDTH, 32, operand/result width in bits (≥8, even)
- FBITS, 10, fraction bits (1 ≤ FBITS < WIDTH; WIDTH+FBITS even)
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  request; sampled only while busy=0
- operation  in  3  opcode: ADD, SUB, MUL, SQRT, NEG, ABS (others reserved)
- operand_1  in  WIDTH  signed fixed-point A
- operand_2  in  WIDTH  signed fixed-point B (ADD/SUB/MUL only)
- result  out  WIDTH  signed fixed-point result, held until next accepted start
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse, result/flags valid
- overflow  out  1  result exceeded range (clamped or wrapped)
- invalid  out  1  SQRT of negative operand

## Operation
- Reset (reset=0): result=0, busy=0, done=0, overflow=0, invalid=0, FSM→IDLE, iteration counter=0; takes effect immediately, aborting any operation in flight with no done pulse.
- Operands and opcode latched on acceptance (start=1 & busy=0); inputs may change afterwards.
- start while busy=1 ignored, no queuing. Reserved opcode: done pulses, result=0, flags=0.
- FSM states: IDLE, MUL_RUN, SQRT_RUN, FINISH. IDLE→FINISH for ADD/SUB/NEG/ABS/reserved/negative SQRT; IDLE→MUL_RUN for MUL; IDLE→SQRT_RUN for non-negative SQRT; RUN→FINISH after last iteration; FINISH→IDLE unconditionally (done=1 in FINISH).
- ADD/SUB: WIDTH+1-bit sum; overflow when sign bits WIDTH and WIDTH−1 differ.
- NEG/ABS: only −2^(WIDTH−1) overflows; SATURATE=1 gives 2^(WIDTH−1)−1, else unchanged.
- MUL: signs recorded, magnitudes (WIDTH bits unsigned) multiplied by radix-2 shift-add over WIDTH cycles into a 2·WIDTH accumulator; add 2^(FBITS−1), shift right FBITS (round half away from zero on magnitude), reapply sign. Overflow when rounded magnitude exceeds 2^(WIDTH−1)−1 (positive) or 2^(WIDTH−1) (negative).
- SQRT: unsigned non-restoring digit recurrence on operand_1·2^FBITS, ITER=(WIDTH+FBITS)/2 iterations, result truncated (floor). Negative operand: result=0, invalid=1, no iteration. Zero: result 0.
- Saturation limits: +max = 2^(WIDTH−1)−1, −max = −2^(WIDTH−1). overflow/invalid valid with done, held with result.

## Timing
- Latency from acceptance edge to done high: ADD/SUB/NEG/ABS/reserved/invalid SQRT 1 cycle; MUL WIDTH+1; SQRT ITER+1 (WIDTH=32, FBITS=10: MUL 33, SQRT 22).
- busy high from cycle after acceptance through final RUN cycle; busy=0 in FINISH, so a new start may be accepted in the same cycle done=1 (back-to-back throughput).
- result, overflow, invalid registered; update only on the done cycle.

## Structure
- Opcode encodings (3-bit) belong in the shared Defines.vh alongside existing FPU opcodes; state encodings local.
- One sub-module: fixed_point_sqrt_core (iterative root engine with load/step/ready), reusable by future units; multiplier stays inline.

## Test plan
- Defaults, ADD 0x00000600 (1.5) + 0x00000900 (2.25) → done after 1 cycle, result 0x00000F00, flags 0.
- MUL 0x00000600 × 0xFFFFF800 (−2.0) → done 33 cycles after start, result 0xFFFFF400 (−3.0); MUL 0x7FFFFC00 × 0x00000800 → 0x7FFFFFFF, overflow=1; with SATURATE=0 overflow=1, result wrapped low bits.
- SQRT 0x00001000 (4.0) → 0x00000800 after 22 cycles; SQRT 0x00000800 (2.0) → 0x000005A8; SQRT 0xFFFFFC00 → result 0, invalid=1 after 1 cycle.
- ADD 0x7FFFFFFF + 0x00000001 → SATURATE=1: 0x7FFFFFFF, overflow=1; SATURATE=0: 0x80000000, overflow=1; NEG 0x80000000 → 0x7FFFFFFF, overflow=1.
- Start MUL, pulse start with new operands at cycle 5 → ignored, original product returned; new start on done cycle accepted and completes.
- Assert reset at MUL iteration 10 → outputs immediately 0, no done pulse; after release, SQRT 0x00001000 completes normally with 0x00000800.

Source files
------------

// File: rtl/fixed_point_alu_pkg.sv
// fixed_point_alu_pkg: opcode encodings shared by fixed_point_alu, its bus interface and issuing logic
package fixed_point_alu_pkg;
    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_SQRT = 3'd3,
        OP_NEG  = 3'd4,
        OP_ABS  = 3'd5
    } op_e;
endpackage

// File: rtl/fixed_point_alu_if.sv
// fixed_point_alu_if: start/busy/done request-response bundle between an issuing stage and fixed_point_alu
interface fixed_point_alu_if
    import fixed_point_alu_pkg::*;
#(
    parameter int WIDTH = 32
) ();
    logic             start_i;
    op_e              op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] result_o;
    logic             busy_o;
    logic             done_o;
    logic             overflow_o;
    logic             invalid_o;
    modport master (output start_i, op_i, a_i, b_i, input result_o, busy_o, done_o, overflow_o, invalid_o);
    modport slave  (input start_i, op_i, a_i, b_i, output result_o, busy_o, done_o, overflow_o, invalid_o);
endinterface

// File: rtl/fixed_point_sqrt_core.sv
// fixed_point_sqrt_core: non-restoring integer square root of an N-bit radicand, one root bit per step
module fixed_point_sqrt_core #(
    parameter int N = 42
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [N-1:0]   radicand_i,
    output logic           ready_o,
    output logic [N/2-1:0] root_o
);
    localparam int H  = N / 2;
    localparam int CW = $clog2(H + 1);
    logic [N-1:0]  rad_q, rad_d;
    logic [H+3:0]  rem_q, rem_d, rem_sh, trial, rem_nx;
    logic [H-1:0]  root_q, root_d, root_nx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run;
    // root_o/ready_o look ahead: during the final step root_o already carries the finished root
    always_comb begin
        run     = step_i && cnt_q != '0;
        rem_sh  = (rem_q << 2) | (H+4)'(rad_q[N-1 -: 2]);
        trial   = {2'b00, root_q, rem_q[H+3] ? 2'b11 : 2'b01};
        rem_nx  = rem_q[H+3] ? rem_sh + trial : rem_sh - trial;
        root_nx = {root_q[H-2:0], ~rem_nx[H+3]};
        rad_d   = load_i ? radicand_i : run ? rad_q << 2 : rad_q;
        rem_d   = load_i ? '0 : run ? rem_nx : rem_q;
        root_d  = load_i ? '0 : run ? root_nx : root_q;
        cnt_d   = load_i ? CW'(H) : run ? cnt_q - 1'b1 : cnt_q;
    end
    assign ready_o = cnt_q == CW'(1);
    assign root_o  = root_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
        end else begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/fixed_point_alu.sv
// fixed_point_alu: signed Q(WIDTH-FBITS).FBITS ADD/SUB/MUL/SQRT/NEG/ABS unit with start/busy/done handshake
module fixed_point_alu
    import fixed_point_alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FBITS    = 10,
    parameter bit SATURATE = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    fixed_point_alu_if.slave bus
);
    localparam int RW = (WIDTH + FBITS) / 2;
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH:0] RND  = (2*WIDTH+1)'(1) << (FBITS - 1);
    localparam logic [2*WIDTH:0] HALF = (2*WIDTH+1)'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL_RUN, SQRT_RUN, FINISH} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d, prod_nx;
    logic [WIDTH-1:0]   mc_q, mc_d, result_q, result_d;
    logic               neg_q, neg_d, ovf_q, ovf_d, inv_q, inv_d;
    logic [WIDTH-1:0]   a, b, mag_a, mag_b, add_res, una_res, mul_lo, mul_res;
    logic [WIDTH:0]     add_sum, mul_sum;
    logic [2*WIDTH:0]   mul_mag;
    logic               add_ovf, una_ovf, mul_ovf, sq_load, sq_step, sq_ready;
    logic [RW-1:0]      sq_root;

    assign a       = bus.a_i;
    assign b       = bus.b_i;
    assign mag_a   = a[WIDTH-1] ? -a : a;
    assign mag_b   = b[WIDTH-1] ? -b : b;
    assign add_sum = {a[WIDTH-1], a} + (bus.op_i == OP_SUB ? -{b[WIDTH-1], b} : {b[WIDTH-1], b});
    assign add_ovf = add_sum[WIDTH] ^ add_sum[WIDTH-1];
    assign add_res = SATURATE && add_ovf ? (add_sum[WIDTH] ? MIN : MAX) : add_sum[WIDTH-1:0];
    assign una_ovf = a == MIN;
    assign una_res = SATURATE && una_ovf ? MAX : (bus.op_i == OP_NEG || a[WIDTH-1] ? -a : a);

    // shift-add: multiplier sits in the low half of prod and drains right as partial sums enter on top
    assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mc_q} : '0);
    assign prod_nx = {mul_sum, prod_q[WIDTH-1:1]};
    assign mul_mag = ({1'b0, prod_nx} + RND) >> FBITS;
    assign mul_ovf = neg_q ? mul_mag > HALF : mul_mag >= HALF;
    assign mul_lo  = mul_mag[WIDTH-1:0];
    assign mul_res = SATURATE && mul_ovf ? (neg_q ? MIN : MAX) : (neg_q ? -mul_lo : mul_lo);

    assign sq_step = state_q == SQRT_RUN;

    fixed_point_sqrt_core #(.N(2 * RW)) u_sqrt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (sq_load),
        .step_i     (sq_step),
        .radicand_i ({a, {FBITS{1'b0}}}),
        .ready_o    (sq_ready),
        .root_o     (sq_root)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mc_d     = mc_q;
        neg_d    = neg_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        inv_d    = inv_q;
        sq_load  = 1'b0;
        case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                if (bus.start_i) begin
                    state_d = FINISH;
                    case (bus.op_i)
                        OP_ADD, OP_SUB: begin
                            result_d = add_res;
                            ovf_d    = add_ovf;
                            inv_d    = 1'b0;
                        end
                        OP_NEG, OP_ABS: begin
                            result_d = una_res;
                            ovf_d    = una_ovf;
                            inv_d    = 1'b0;
                        end
                        OP_MUL: begin
                            state_d = MUL_RUN;
                            cnt_d   = '0;
                            prod_d  = {{WIDTH{1'b0}}, mag_b};
                            mc_d    = mag_a;
                            neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                        end
                        OP_SQRT: begin
                            state_d  = a[WIDTH-1] ? FINISH : SQRT_RUN;
                            sq_load  = !a[WIDTH-1];
                            result_d = a[WIDTH-1] ? '0 : result_q;
                            ovf_d    = a[WIDTH-1] ? 1'b0 : ovf_q;
                            inv_d    = a[WIDTH-1] ? 1'b1 : inv_q;
                        end
                        default: begin
                            result_d = '0;
                            ovf_d    = 1'b0;
                            inv_d    = 1'b0;
                        end
                    endcase
                end
            end
            MUL_RUN: begin
                prod_d = prod_nx;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = FINISH;
                    cnt_d    = '0;
                    result_d = mul_res;
                    ovf_d    = mul_ovf;
                    inv_d    = 1'b0;
                end
            end
            SQRT_RUN: begin
                if (sq_ready) begin
                    state_d  = FINISH;
                    result_d = WIDTH'(sq_root);
                    ovf_d    = 1'b0;
                    inv_d    = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            mc_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mc_q     <= mc_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
        end
    end

    assign bus.result_o   = result_q;
    assign bus.busy_o     = state_q == MUL_RUN || state_q == SQRT_RUN;
    assign bus.done_o     = state_q == FINISH;
    assign bus.overflow_o = ovf_q;
    assign bus.invalid_o  = inv_q;
endmodule

// File: tb/tb_fixed_point_alu.sv
// tb_fixed_point_alu: directed vectors against saturating and wrapping instances sharing one stimulus bus
module tb_fixed_point_alu;
    import fixed_point_alu_pkg::*;

    typedef struct {
        op_e         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rs;
        logic [31:0] rw;
        logic        ovf;
        logic        inv;
        int          lat;
    } vec_t;

    localparam int NV = 19;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t v[NV];

    fixed_point_alu_if #(.WIDTH(32)) bus_s ();
    fixed_point_alu_if #(.WIDTH(32)) bus_w ();

    assign bus_w.start_i = bus_s.start_i;
    assign bus_w.op_i    = bus_s.op_i;
    assign bus_w.a_i     = bus_s.a_i;
    assign bus_w.b_i     = bus_s.b_i;

    fixed_point_alu #(.WIDTH(32), .FBITS(10), .SATURATE(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
    fixed_point_alu #(.WIDTH(32), .FBITS(10), .SATURATE(1'b0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input op_e op, input logic [31:0] a, input logic [31:0] b);
        bus_s.op_i    = op;
        bus_s.a_i     = a;
        bus_s.b_i     = b;
        bus_s.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus_s.start_i = 1'b0;
        bus_s.op_i    = OP_NEG;
        bus_s.a_i     = ~a;
        bus_s.b_i     = ~b;
    endtask

    task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive(op, a, b);
    endtask

    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus_s.done_o && k < 100);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".res_s"}, 64'(bus_s.result_o), 64'h0);
        check({tag, ".res_w"}, 64'(bus_w.result_o), 64'h0);
        check({tag, ".busy"}, 64'({bus_s.busy_o, bus_w.busy_o}), 64'h0);
        check({tag, ".done"}, 64'({bus_s.done_o, bus_w.done_o}), 64'h0);
        check({tag, ".flags"}, 64'({bus_s.overflow_o, bus_s.invalid_o, bus_w.overflow_o, bus_w.invalid_o}), 64'h0);
    endtask

    initial begin
        int k;
        int dones;
        v[0]  = '{OP_ADD,      32'h00000600, 32'h00000900, 32'h00000F00, 32'h00000F00, 1'b0, 1'b0, 1};
        v[1]  = '{OP_SUB,      32'h00000600, 32'h00000900, 32'hFFFFFD00, 32'hFFFFFD00, 1'b0, 1'b0, 1};
        v[2]  = '{OP_MUL,      32'h00000600, 32'hFFFFF800, 32'hFFFFF400, 32'hFFFFF400, 1'b0, 1'b0, 33};
        v[3]  = '{OP_MUL,      32'h7FFFFC00, 32'h00000800, 32'h7FFFFFFF, 32'hFFFFF800, 1'b1, 1'b0, 33};
        v[4]  = '{OP_SQRT,     32'h00001000, 32'h00000000, 32'h00000800, 32'h00000800, 1'b0, 1'b0, 22};
        v[5]  = '{OP_SQRT,     32'h00000800, 32'h00000000, 32'h000005A8, 32'h000005A8, 1'b0, 1'b0, 22};
        v[6]  = '{OP_SQRT,     32'hFFFFFC00, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1};
        v[7]  = '{OP_ADD,      32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 1};
        v[8]  = '{OP_NEG,      32'h80000000, 32'h00000000, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 1};
        v[9]  = '{OP_ABS,      32'hFFFFF400, 32'h00000000, 32'h00000C00, 32'h00000C00, 1'b0, 1'b0, 1};
        v[10] = '{OP_NEG,      32'h00000600, 32'h00000000, 32'hFFFFFA00, 32'hFFFFFA00, 1'b0, 1'b0, 1};
        v[11] = '{op_e'(3'd7), 32'h00001234, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1};
        v[12] = '{OP_MUL,      32'h00000001, 32'h00000200, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 33};
        v[13] = '{OP_MUL,      32'hFFFFFFFF, 32'h00000200, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 33};
        v[14] = '{OP_SUB,      32'h80000000, 32'h00000001, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
        v[15] = '{OP_SQRT,     32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 22};
        v[16] = '{OP_MUL,      32'h80000000, 32'h00000400, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 33};
        v[17] = '{OP_MUL,      32'h80000000, 32'hFFFFFC00, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 33};
        v[18] = '{OP_ABS,      32'h80000000, 32'h00000000, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 1};

        bus_s.start_i = 1'b0;
        bus_s.op_i    = OP_ADD;
        bus_s.a_i     = '0;
        bus_s.b_i     = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            issue(v[i].op, v[i].a, v[i].b);
            wait_done(k);
            check($sformatf("v%0d.latency", i), 64'(k), 64'(v[i].lat));
            check($sformatf("v%0d.done_w", i), 64'(bus_w.done_o), 64'h1);
            check($sformatf("v%0d.res_s", i), 64'(bus_s.result_o), 64'(v[i].rs));
            check($sformatf("v%0d.res_w", i), 64'(bus_w.result_o), 64'(v[i].rw));
            check($sformatf("v%0d.flags_s", i), 64'({bus_s.overflow_o, bus_s.invalid_o}), 64'({v[i].ovf, v[i].inv}));
            check($sformatf("v%0d.flags_w", i), 64'({bus_w.overflow_o, bus_w.invalid_o}), 64'({v[i].ovf, v[i].inv}));
            @(negedge clk);
            check($sformatf("v%0d.pulse", i), 64'({bus_s.done_o, bus_w.done_o}), 64'h0);
            check($sformatf("v%0d.hold", i), 64'(bus_s.result_o), 64'(v[i].rs));
        end

        issue(OP_MUL, 32'h00000600, 32'hFFFFF800);
        @(negedge clk);
        check("ign.busy", 64'(bus_s.busy_o), 64'h1);
        repeat (4) @(negedge clk);
        drive(OP_ADD, 32'h00000100, 32'h00000100);
        wait_done(k);
        check("ign.latency", 64'(k), 64'd28);
        check("ign.res", 64'(bus_s.result_o), 64'hFFFFF400);
        check("b2b.busy", 64'(bus_s.busy_o), 64'h0);
        drive(OP_ADD, 32'h00000600, 32'h00000900);
        @(negedge clk);
        check("b2b.done", 64'(bus_s.done_o), 64'h1);
        check("b2b.res", 64'(bus_s.result_o), 64'h00000F00);
        @(negedge clk);
        check("b2b.pulse", 64'(bus_s.done_o), 64'h0);

        issue(OP_MUL, 32'h00000600, 32'hFFFFF800);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("abort");
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            dones += int'(bus_s.done_o | bus_w.done_o);
        end
        check("abort.no_done", 64'(dones), 64'h0);
        issue(OP_SQRT, 32'h00001000, 32'h00000000);
        wait_done(k);
        check("post.latency", 64'(k), 64'd22);
        check("post.res", 64'(bus_s.result_o), 64'h00000800);
        check("post.flags", 64'({bus_s.overflow_o, bus_s.invalid_o}), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
